// File: rtl/nts_rx_axis_adapter_pkg.sv
// Shared definitions for the NTS MAC RX AXI4-Stream adapter: Ethernet frame
// limits, bus geometry and the receive FSM state encoding.
package nts_rx_axis_adapter_pkg;

    localparam int BYTES_PER_WORD = 8;
    localparam int ETH_MIN_BYTES  = 60;
    localparam int ETH_MAX_BYTES  = 1518;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_DROP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/nts_keep_check.sv
// Combinational tkeep analysis for one 8-byte beat: number of enabled bytes,
// whether the enables form a run starting at byte 0, and whether all are set.
module nts_keep_check
    import nts_rx_axis_adapter_pkg::*;
(
    input  logic [BYTES_PER_WORD-1:0] keep_i,
    output logic [3:0]                popcount_o,
    output logic                      contiguous_o,
    output logic                      full_o
);

    logic [BYTES_PER_WORD-1:0] keep_inc;

    // A run of ones from bit 0 is exactly a value of the form 2^k-1,
    // so adding one carries through every set bit and leaves no overlap.
    always_comb begin
        popcount_o = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            popcount_o = popcount_o + {3'b000, keep_i[i]};
        end
        keep_inc     = keep_i + BYTES_PER_WORD'(1);
        contiguous_o = ((keep_i & keep_inc) == '0);
        full_o       = &keep_i;
    end

endmodule

// File: rtl/nts_rx_axis_adapter.sv
// AXI4-Stream (64-bit) to NTS MAC RX adapter. Converts keep/data to the
// byte-reversed NTS layout with one register stage, validates frame length
// and keep shape, drops oversize frames and keeps saturating statistics.
// There is no back-pressure: every input beat is consumed in its cycle.
module nts_rx_axis_adapter
    import nts_rx_axis_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MIN_BYTES  = ETH_MIN_BYTES,
    parameter int MAX_BYTES  = ETH_MAX_BYTES,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      i_areset,
    input  logic                      i_clk,
    input  logic                      i_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     i_axis_tdata,
    input  logic [BYTES_PER_WORD-1:0] i_axis_tkeep,
    input  logic                      i_axis_tlast,
    input  logic                      i_axis_tuser,
    output logic [BYTES_PER_WORD-1:0] o_mac_rx_data_valid,
    output logic [DATA_WIDTH-1:0]     o_mac_rx_data,
    output logic                      o_mac_rx_good_frame,
    output logic                      o_mac_rx_bad_frame,
    output logic [CNT_WIDTH-1:0]      o_cnt_good,
    output logic [CNT_WIDTH-1:0]      o_cnt_bad,
    output logic [CNT_WIDTH-1:0]      o_cnt_oversize
);

    function automatic logic [LEN_WIDTH-1:0] sat_add_len(input logic [LEN_WIDTH-1:0] a,
                                                         input logic [3:0]           b);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, a} + {{(LEN_WIDTH-3){1'b0}}, b};
        return sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] c,
                                                         input logic                 en);
        if (en && (c != '1)) begin
            return c + CNT_WIDTH'(1);
        end
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] o;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            o[8*(BYTES_PER_WORD-1-i) +: 8] = d[8*i +: 8];
        end
        return o;
    endfunction

    function automatic logic [BYTES_PER_WORD-1:0] keep_rev(input logic [BYTES_PER_WORD-1:0] k);
        logic [BYTES_PER_WORD-1:0] o;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            o[BYTES_PER_WORD-1-i] = k[i];
        end
        return o;
    endfunction

    rx_state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic                      drop_ovs_q, drop_ovs_d;
    logic [BYTES_PER_WORD-1:0] valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      good_q, good_d;
    logic                      bad_q, bad_d;
    logic                      ovs_evt;
    logic [CNT_WIDTH-1:0]      cnt_good_q, cnt_good_d;
    logic [CNT_WIDTH-1:0]      cnt_bad_q, cnt_bad_d;
    logic [CNT_WIDTH-1:0]      cnt_ovs_q, cnt_ovs_d;

    logic [3:0]                keep_pop;
    logic                      keep_contig;
    logic                      keep_full;
    logic [LEN_WIDTH-1:0]      len_acc;
    logic [LEN_WIDTH-1:0]      len_beat;
    logic                      frame_good;

    nts_keep_check u_keep_check (
        .keep_i       (i_axis_tkeep),
        .popcount_o   (keep_pop),
        .contiguous_o (keep_contig),
        .full_o       (keep_full)
    );

    // Frame status terms for the current beat; len_beat is the post-beat length.
    always_comb begin
        len_acc    = sat_add_len(len_q, keep_pop);
        len_beat   = (state_q == ST_FRAME) ? len_acc : LEN_WIDTH'(keep_pop);
        frame_good = !i_axis_tuser && keep_contig && (keep_pop != 4'd0) &&
                     (len_beat >= LEN_WIDTH'(MIN_BYTES)) &&
                     (len_beat <= LEN_WIDTH'(MAX_BYTES));
    end

    // Next state, output word and status pulses; data holds unless a beat is emitted.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        drop_ovs_d = drop_ovs_q;
        valid_d    = '0;
        data_d     = data_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        ovs_evt    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (i_axis_tvalid && i_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_axis_tvalid) begin
                    len_d = LEN_WIDTH'(keep_pop);
                    if (i_axis_tlast) begin
                        valid_d = keep_rev(i_axis_tkeep);
                        data_d  = byte_swap(i_axis_tdata);
                        good_d  = frame_good;
                        bad_d   = !frame_good;
                    end else if (!keep_full) begin
                        drop_ovs_d = 1'b0;
                        state_d    = ST_DROP;
                    end else begin
                        valid_d = keep_rev(i_axis_tkeep);
                        data_d  = byte_swap(i_axis_tdata);
                        state_d = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                if (i_axis_tvalid) begin
                    len_d = len_acc;
                    if (len_acc > LEN_WIDTH'(MAX_BYTES)) begin
                        // Oversize: nothing past the limit is delivered.
                        if (i_axis_tlast) begin
                            bad_d   = 1'b1;
                            ovs_evt = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            drop_ovs_d = 1'b1;
                            state_d    = ST_DROP;
                        end
                    end else if (i_axis_tlast) begin
                        valid_d = keep_rev(i_axis_tkeep);
                        data_d  = byte_swap(i_axis_tdata);
                        good_d  = frame_good;
                        bad_d   = !frame_good;
                        state_d = ST_IDLE;
                    end else if (!keep_full) begin
                        drop_ovs_d = 1'b0;
                        state_d    = ST_DROP;
                    end else begin
                        valid_d = keep_rev(i_axis_tkeep);
                        data_d  = byte_swap(i_axis_tdata);
                    end
                end
            end
            ST_DROP: begin
                if (i_axis_tvalid && i_axis_tlast) begin
                    bad_d   = 1'b1;
                    ovs_evt = drop_ovs_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
        cnt_good_d = sat_inc_cnt(cnt_good_q, good_d);
        cnt_bad_d  = sat_inc_cnt(cnt_bad_q, bad_d);
        cnt_ovs_d  = sat_inc_cnt(cnt_ovs_q, ovs_evt);
    end

    // State, length counter, output stage and statistics; reset enters SYNC.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= ST_SYNC;
            len_q      <= '0;
            drop_ovs_q <= 1'b0;
            valid_q    <= '0;
            data_q     <= '0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
            cnt_ovs_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            drop_ovs_q <= drop_ovs_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            cnt_good_q <= cnt_good_d;
            cnt_bad_q  <= cnt_bad_d;
            cnt_ovs_q  <= cnt_ovs_d;
        end
    end

    assign o_mac_rx_data_valid = valid_q;
    assign o_mac_rx_data       = data_q;
    assign o_mac_rx_good_frame = good_q;
    assign o_mac_rx_bad_frame  = bad_q;
    assign o_cnt_good          = cnt_good_q;
    assign o_cnt_bad           = cnt_bad_q;
    assign o_cnt_oversize      = cnt_ovs_q;

endmodule

// File: tb/tb_nts_rx_axis_adapter.sv
// Testbench for nts_rx_axis_adapter: reset/resync sequences, a table of
// frame-level vectors with hand-derived outcomes, and randomized frames
// checked cycle by cycle against a frame-level reference model.
module tb_nts_rx_axis_adapter;

    localparam int MINB = 60;
    localparam int MAXB = 1518;

    logic        clk = 1'b0;
    logic        areset;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        good;
    logic        bad;
    logic [31:0] cnt_good;
    logic [31:0] cnt_bad;
    logic [31:0] cnt_ovs;

    always #5 clk = ~clk;

    nts_rx_axis_adapter dut (
        .i_areset            (areset),
        .i_clk               (clk),
        .i_axis_tvalid       (tvalid),
        .i_axis_tdata        (tdata),
        .i_axis_tkeep        (tkeep),
        .i_axis_tlast        (tlast),
        .i_axis_tuser        (tuser),
        .o_mac_rx_data_valid (mask),
        .o_mac_rx_data       (data),
        .o_mac_rx_good_frame (good),
        .o_mac_rx_bad_frame  (bad),
        .o_cnt_good          (cnt_good),
        .o_cnt_bad           (cnt_bad),
        .o_cnt_oversize      (cnt_ovs)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_data;
    int          m_good, m_bad, m_ovs;
    bit          m_synced;

    // Current frame and its expected per-beat behaviour
    logic [7:0]  f_keep [256];
    logic [63:0] f_data [256];
    int          f_n;
    logic        f_user;
    bit          x_emit [256];
    bit          x_good, x_bad, x_ovs;

    // Observations over the last frame
    int          o_words;
    bit          o_good, o_bad;

    typedef struct {
        int         nbytes;
        logic       user;
        int         mid_idx;
        logic [7:0] mid_keep;
        int         last_keep;
        int         gap;
        bit         exp_good;
        bit         exp_bad;
        bit         exp_ovs;
        int         exp_words;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [63:0] swap64(input logic [63:0] d);
        return {<<8{d}};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] k);
        return {<<{k}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                         input logic l, input logic u);
        tvalid = v;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tuser  = u;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] em, input logic [63:0] ed,
                             input logic eg, input logic eb);
        chk({tag, " mask"}, 64'(mask), 64'(em));
        chk({tag, " data"}, data, ed);
        chk({tag, " good"}, 64'(good), 64'(eg));
        chk({tag, " bad"},  64'(bad),  64'(eb));
    endtask

    task automatic check_counters(input string tag);
        chk({tag, " cnt_good"},     64'(cnt_good), 64'(m_good));
        chk({tag, " cnt_bad"},      64'(cnt_bad),  64'(m_bad));
        chk({tag, " cnt_oversize"}, 64'(cnt_ovs),  64'(m_ovs));
    endtask

    task automatic build_frame(input int nbytes, input logic user, input int mid_idx,
                               input logic [7:0] mid_keep, input int last_keep);
        int rem;
        f_n = (nbytes + 7) / 8;
        if (f_n == 0) f_n = 1;
        for (int i = 0; i < f_n; i++) begin
            f_keep[i] = 8'hFF;
            f_data[i] = {$urandom, $urandom};
        end
        rem = nbytes - 8 * (f_n - 1);
        f_keep[f_n-1] = 8'((1 << rem) - 1);
        if (mid_idx >= 0 && mid_idx < f_n - 1) f_keep[mid_idx] = mid_keep;
        if (last_keep >= 0) f_keep[f_n-1] = 8'(last_keep);
        f_user = user;
    endtask

    // Frame-level reference: which beats are delivered and how the frame ends.
    task automatic model_frame();
        int  len;
        bit  alive;
        bit  over;
        int  pc;
        bit  legal_last;
        logic [7:0] lk;
        for (int i = 0; i < f_n; i++) x_emit[i] = 0;
        x_good = 0; x_bad = 0; x_ovs = 0;
        if (!m_synced) begin
            m_synced = 1;
            return;
        end
        len = 0; alive = 1; over = 0;
        for (int i = 0; i < f_n; i++) begin
            pc = $countones(f_keep[i]);
            len = len + pc;
            if (alive) begin
                if (len > MAXB) begin
                    alive = 0;
                    over  = 1;
                end else if (i == f_n - 1) begin
                    x_emit[i] = 1;
                end else if (f_keep[i] != 8'hFF) begin
                    alive = 0;
                end else begin
                    x_emit[i] = 1;
                end
            end
        end
        lk = f_keep[f_n-1];
        legal_last = (lk != 8'h00) && (lk == 8'((1 << $countones(lk)) - 1));
        if (!alive) begin
            x_bad = 1;
            x_ovs = over;
        end else begin
            x_good = !f_user && legal_last && (len >= MINB) && (len <= MAXB);
            x_bad  = !x_good;
        end
    endtask

    task automatic send_frame(input int gap_pct, input string tag);
        logic [7:0] em;
        logic       last;
        int         g;
        model_frame();
        o_words = 0; o_good = 0; o_bad = 0;
        for (int i = 0; i < f_n; i++) begin
            if (i > 0) begin
                g = 0;
                while (g < 4 && $urandom_range(0, 99) < gap_pct) begin
                    drive(1'b0, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom));
                    check_out({tag, " gap"}, 8'h00, m_data, 1'b0, 1'b0);
                    g++;
                end
            end
            last = (i == f_n - 1);
            drive(1'b1, f_data[i], f_keep[i], last, last ? f_user : 1'($urandom));
            em = x_emit[i] ? rev8(f_keep[i]) : 8'h00;
            if (x_emit[i]) m_data = swap64(f_data[i]);
            check_out(tag, em, m_data, last && x_good, last && x_bad);
            if (mask != 8'h00) o_words++;
            if (good) o_good = 1;
            if (bad)  o_bad  = 1;
        end
        if (x_good) m_good++;
        if (x_bad)  m_bad++;
        if (x_ovs)  m_ovs++;
        check_counters(tag);
    endtask

    initial begin
        int ovs_before;
        int nb;
        string tag;

        //             bytes user mid  midkeep last gap good bad ovs words
        tbl[0]  = '{64,   1'b0, -1, 8'h00, -1,   0, 1, 0, 0, 8};
        tbl[1]  = '{64,   1'b0, -1, 8'h00, -1,   0, 1, 0, 0, 8};
        tbl[2]  = '{61,   1'b0, -1, 8'h00, -1,   0, 1, 0, 0, 8};
        tbl[3]  = '{61,   1'b1, -1, 8'h00, -1,   0, 0, 1, 0, 8};
        tbl[4]  = '{20,   1'b0, -1, 8'h00, -1,   0, 0, 1, 0, 3};
        tbl[5]  = '{70,   1'b0, -1, 8'h00, 5,    0, 0, 1, 0, 9};
        tbl[6]  = '{1600, 1'b0, -1, 8'h00, -1,   0, 0, 1, 1, 189};
        tbl[7]  = '{1518, 1'b0, -1, 8'h00, -1,   0, 1, 0, 0, 190};
        tbl[8]  = '{1519, 1'b0, -1, 8'h00, -1,   0, 0, 1, 1, 189};
        tbl[9]  = '{60,   1'b0, -1, 8'h00, -1,   0, 1, 0, 0, 8};
        tbl[10] = '{59,   1'b0, -1, 8'h00, -1,   0, 0, 1, 0, 8};
        tbl[11] = '{64,   1'b0, 1,  8'h7F, -1,   0, 0, 1, 0, 1};
        tbl[12] = '{64,   1'b0, 0,  8'h0F, -1,   0, 0, 1, 0, 0};
        tbl[13] = '{8,    1'b0, -1, 8'h00, -1,   0, 0, 1, 0, 1};
        tbl[14] = '{64,   1'b0, -1, 8'h00, -1,   40, 1, 0, 0, 8};

        areset = 1'b1;
        tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
        m_data = '0; m_good = 0; m_bad = 0; m_ovs = 0; m_synced = 0;
        repeat (3) @(negedge clk);
        check_out("reset", 8'h00, 64'h0, 1'b0, 1'b0);
        check_counters("reset");
        areset = 1'b0;

        // After reset the first frame only resynchronises and is discarded.
        build_frame(64, 1'b0, -1, 8'h00, -1);
        send_frame(0, "sync");

        // Reset pulse in the middle of a frame: the tail is discarded, no pulse.
        build_frame(64, 1'b0, -1, 8'h00, -1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                areset = 1'b1;
                #1;
                chk("async reset mask", 64'(mask), 64'h0);
                m_data = '0;
                m_good = 0; m_bad = 0; m_ovs = 0;
                m_synced = 0;
            end
            if (i == 4) areset = 1'b0;
            drive(1'b1, f_data[i], f_keep[i], i == 7, 1'b0);
            if (i < 2) m_data = swap64(f_data[i]);
            check_out("midreset", (i < 2) ? 8'hFF : 8'h00, m_data, 1'b0, 1'b0);
        end
        m_synced = 1;
        check_counters("midreset");

        for (int t = 0; t < 15; t++) begin
            tag = $sformatf("vec%0d", t);
            ovs_before = m_ovs;
            build_frame(tbl[t].nbytes, tbl[t].user, tbl[t].mid_idx, tbl[t].mid_keep, tbl[t].last_keep);
            send_frame(tbl[t].gap, tag);
            chk({tag, " good_seen"}, 64'(o_good), 64'(tbl[t].exp_good));
            chk({tag, " bad_seen"},  64'(o_bad),  64'(tbl[t].exp_bad));
            chk({tag, " words"},     64'(o_words), 64'(tbl[t].exp_words));
            chk({tag, " oversize"},  64'(cnt_ovs), 64'(ovs_before + int'(tbl[t].exp_ovs)));
        end

        for (int r = 0; r < 40; r++) begin
            tag = $sformatf("rnd%0d", r);
            nb = int'($urandom_range(0, 1700));
            build_frame(nb, 1'($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 200)) : -1,
                        8'($urandom),
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : -1);
            send_frame(int'($urandom_range(0, 30)), tag);
        end

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check_out("idle", 8'h00, m_data, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
